// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx AXI-Stream byte input among N_PORTS.
// Define UART_ARB_TIMEOUT_EN to force-release a source stalled mid-packet for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int N_PORTS        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int IDX_W         = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_PORTS-1:0]            s_axis_tvalid,
    input  logic [N_PORTS-1:0]            s_axis_tlast,
    output logic [N_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          timeout_pulse
);

    if (N_PORTS < 2 || N_PORTS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    typedef enum logic [0:0] {StIdle, StXfer} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;

    logic [IDX_W:0]          rr_sum;
    logic [IDX_W-1:0]        rr_cand;
    logic [IDX_W-1:0]        rr_pick;
    logic                    rr_found;

    logic                    g_valid;
    logic                    g_last;
    logic [DATA_WIDTH-1:0]   g_data;
    logic                    can_load;
    logic                    accept;
    logic                    timeout_hit;

    // Search starts just after the last owner; the sum is one bit wider so the wrap is exact
    // for any N_PORTS, not only powers of two.
    always_comb begin
        rr_sum   = '0;
        rr_cand  = '0;
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= N_PORTS; i++) begin
            rr_sum = {1'b0, last_grant_q} + (IDX_W + 1)'(i);
            if (rr_sum >= (IDX_W + 1)'(N_PORTS)) begin
                rr_sum = rr_sum - (IDX_W + 1)'(N_PORTS);
            end
            rr_cand = rr_sum[IDX_W-1:0];
            if (!rr_found && s_axis_tvalid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    assign g_valid  = s_axis_tvalid[grant_idx_q];
    assign g_last   = s_axis_tlast[grant_idx_q];
    assign g_data   = s_axis_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign can_load = !m_valid_q || m_axis_tready;
    assign accept   = (state_q == StXfer) && g_valid && can_load && !timeout_hit;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_q, stall_d;

    assign timeout_hit = (state_q == StXfer) && (stall_q == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero while idle, so a fresh grant always starts a full stall budget.
    always_comb begin
        stall_d = stall_q;
        if (state_q == StIdle || accept || timeout_hit) begin
            stall_d = '0;
        end else if (!g_valid) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            last_grant_q  <= IDX_W'(N_PORTS - 1);
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_idx_d   = rr_pick;
                    grant_valid_d = 1'b1;
                    state_d       = StXfer;
                end
            end
            StXfer: begin
                if ((accept && g_last) || timeout_hit) begin
                    last_grant_d  = grant_idx_q;
                    grant_valid_d = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The final byte may still be draining here while the next arbitration is under way.
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        if (accept) begin
            m_data_d  = g_data;
            m_valid_d = 1'b1;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_comb begin
        s_axis_tready = '0;
        if (state_q == StXfer && can_load && !timeout_hit) begin
            s_axis_tready[grant_idx_q] = 1'b1;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign grant_valid   = grant_valid_q;
    assign grant_idx     = grant_idx_q;
    assign timeout_pulse = timeout_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic scored against a
// round-robin packet-order model; the stall-release scenario follows UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            grant_valid;
    logic [1:0]      grant_idx;
    logic            timeout_pulse;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] pb [N][$];
    bit         pl [N][$];
    int         exp_grants [$];
    logic [7:0] exp_bytes [$];
    bit         vld [N];
    bit         mid [N];
    bit         acc [N];

    uart_tx_arbiter #(
        .N_PORTS       (N),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .timeout_pulse(timeout_pulse)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic drive(input int p, input logic [7:0] d, input logic v, input logic l);
        s_tdata[p*DW +: DW] = d;
        s_tvalid[p]         = v;
        s_tlast[p]          = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_one(input int p, input logic [7:0] d);
        bit done = 1'b0;
        @(negedge clk);
        drive(p, d, 1'b1, 1'b1);
        for (int i = 0; i < 10 && !done; i++) begin
            #1;
            done = s_tready[p];
            @(negedge clk);
        end
        drive(p, 8'h00, 1'b0, 1'b0);
        check("send_one accepted", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic add_packet(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            pb[p].push_back(8'($urandom_range(255)));
            pl[p].push_back(i == len - 1);
        end
    endtask

    // Reference: strict round robin over ports that still hold packets, starting after port N-1.
    task automatic build_expected();
        logic [7:0] cb [N][$];
        bit         cl [N][$];
        int         ptr  = N - 1;
        bit         done = 1'b0;
        int         sel;
        bit         l;
        for (int p = 0; p < N; p++) begin
            cb[p] = pb[p];
            cl[p] = pl[p];
        end
        exp_grants.delete();
        exp_bytes.delete();
        while (!done) begin
            sel = -1;
            for (int k = 1; k <= N; k++) begin
                if (sel < 0 && cb[(ptr + k) % N].size() > 0) sel = (ptr + k) % N;
            end
            if (sel < 0) begin
                done = 1'b1;
            end else begin
                ptr = sel;
                exp_grants.push_back(sel);
                l = 1'b0;
                while (!l) begin
                    exp_bytes.push_back(cb[sel].pop_front());
                    l = cl[sel].pop_front();
                end
            end
        end
    endtask

    task automatic run_traffic(input int bubble_pct, input int stall_pct, input int hold_from,
                               input int hold_len, input int max_cycles);
        int         cyc        = 0;
        bit         prev_gv    = 1'b0;
        bit         released   = 1'b0;
        int         idle_run   = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data  = '0;
        logic [N-1:0] allowed;
        int         left;
        for (int p = 0; p < N; p++) begin
            vld[p] = 1'b0;
            mid[p] = 1'b0;
            acc[p] = 1'b0;
        end
        build_expected();
        while (exp_bytes.size() > 0 && cyc < max_cycles) begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                if (acc[p]) begin
                    void'(pb[p].pop_front());
                    mid[p] = !pl[p].pop_front();
                    vld[p] = 1'b0;
                end
                // Sources only bubble mid-packet, so every pending packet is visible at arbitration.
                if (!vld[p] && pb[p].size() > 0) begin
                    vld[p] = mid[p] ? ($urandom_range(99) >= bubble_pct) : 1'b1;
                end
                drive(p, vld[p] ? pb[p][0] : 8'h00, vld[p], vld[p] ? pl[p][0] : 1'b0);
            end
            if (cyc >= hold_from && cyc < hold_from + hold_len) m_tready = 1'b0;
            else m_tready = ($urandom_range(99) >= stall_pct);
            #1;
            if (prev_stall) begin
                check("stall holds valid", {31'd0, m_tvalid}, 32'd1);
                check("stall holds data", {24'd0, m_tdata}, {24'd0, prev_data});
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            if (m_tvalid && !m_tready) check("ready under stall", {28'd0, s_tready}, 32'd0);
            allowed = grant_valid ? (N'(1) << grant_idx) : '0;
            check("ready only to owner", {28'd0, s_tready & ~allowed}, 32'd0);
            if (grant_valid && !prev_gv) begin
                check("grant order", {30'd0, grant_idx},
                      exp_grants.size() > 0 ? exp_grants.pop_front() : 32'hffff);
                if (released) check("idle gap", idle_run, 32'd1);
            end
            if (!grant_valid && prev_gv) begin
                released = 1'b1;
                idle_run = 0;
            end
            if (!grant_valid) idle_run++;
            prev_gv = grant_valid;
            if (m_tvalid && m_tready) begin
                check("stream byte", {24'd0, m_tdata},
                      exp_bytes.size() > 0 ? {24'd0, exp_bytes.pop_front()} : 32'h1ff);
            end
            for (int p = 0; p < N; p++) acc[p] = s_tvalid[p] && s_tready[p];
            cyc++;
        end
        check("traffic completed", exp_bytes.size(), 32'd0);
        @(negedge clk);
        for (int p = 0; p < N; p++) if (acc[p]) begin
            void'(pb[p].pop_front());
            void'(pl[p].pop_front());
        end
        idle_inputs();
        m_tready = 1'b1;
        left = 0;
        for (int p = 0; p < N; p++) left += pb[p].size();
        check("sources drained", left, 32'd0);
        check("grants consumed", exp_grants.size(), 32'd0);
        for (int p = 0; p < N; p++) begin
            pb[p].delete();
            pl[p].delete();
        end
    endtask

    initial begin
        int hit_at;
        rst      = 1'b1;
        m_tready = 1'b0;
        idle_inputs();

        // Reset values
        do_reset();
        #1;
        check("reset s_tready", {28'd0, s_tready}, 32'd0);
        check("reset m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("reset m_tdata", {24'd0, m_tdata}, 32'd0);
        check("reset grant_valid", {31'd0, grant_valid}, 32'd0);
        check("reset grant_idx", {30'd0, grant_idx}, 32'd0);
        check("reset timeout_pulse", {31'd0, timeout_pulse}, 32'd0);

        // Single port 2 packet 41 42 43
        drive(2, 8'h41, 1'b1, 1'b0);
        #1;
        check("single: no grant yet", {31'd0, grant_valid}, 32'd0);
        @(negedge clk); #1;
        check("single: grant_valid", {31'd0, grant_valid}, 32'd1);
        check("single: grant_idx", {30'd0, grant_idx}, 32'd2);
        check("single: ready", {28'd0, s_tready}, 32'h4);
        check("single: m_tvalid late", {31'd0, m_tvalid}, 32'd0);
        @(negedge clk);
        drive(2, 8'h42, 1'b1, 1'b0);
        #1;
        check("single: byte0 valid", {31'd0, m_tvalid}, 32'd1);
        check("single: byte0", {24'd0, m_tdata}, 32'h41);
        @(negedge clk);
        drive(2, 8'h43, 1'b1, 1'b1);
        #1;
        check("single: byte1", {24'd0, m_tdata}, 32'h42);
        check("single: grant held", {31'd0, grant_valid}, 32'd1);
        @(negedge clk);
        drive(2, 8'h00, 1'b0, 1'b0);
        #1;
        check("single: byte2", {24'd0, m_tdata}, 32'h43);
        check("single: released", {31'd0, grant_valid}, 32'd0);
        @(negedge clk); #1;
        check("single: drained", {31'd0, m_tvalid}, 32'd0);

        // Round robin, ports 0 1 3, two 2-byte packets each
        do_reset();
        for (int r = 0; r < 2; r++) begin
            add_packet(0, 2);
            add_packet(1, 2);
            add_packet(3, 2);
        end
        run_traffic(0, 0, 0, 0, 200);

        // Backpressure: 10-cycle stall mid-packet
        do_reset();
        add_packet(0, 6);
        add_packet(2, 3);
        run_traffic(0, 0, 4, 10, 200);

        // Wrap: last owner 3, ports 0 and 3 requesting
        do_reset();
        send_one(1, 8'h11);
        send_one(3, 8'h33);
        @(negedge clk);
        drive(0, 8'h01, 1'b1, 1'b1);
        drive(3, 8'h03, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("wrap: grant_valid", {31'd0, grant_valid}, 32'd1);
        check("wrap: grant_idx", {30'd0, grant_idx}, 32'd0);

        // Reset in the middle of a 4-byte packet
        do_reset();
        send_one(0, 8'h10);
        @(negedge clk);
        drive(2, 8'hA0, 1'b1, 1'b0);
        @(negedge clk); #1;
        check("rst: p2 granted", {30'd0, grant_idx}, 32'd2);
        @(negedge clk);
        drive(2, 8'hA1, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        drive(0, 8'h20, 1'b1, 1'b1);
        drive(1, 8'h30, 1'b1, 1'b1);
        #1;
        check("rst: s_tready", {28'd0, s_tready}, 32'd0);
        check("rst: m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst: m_tdata", {24'd0, m_tdata}, 32'd0);
        check("rst: grant_valid", {31'd0, grant_valid}, 32'd0);
        check("rst: grant_idx", {30'd0, grant_idx}, 32'd0);
        check("rst: timeout_pulse", {31'd0, timeout_pulse}, 32'd0);
        @(negedge clk); #1;
        check("rst: pointer restart", {30'd0, grant_idx}, 32'd0);
        check("rst: regrant", {31'd0, grant_valid}, 32'd1);

        // Randomized traffic with bubbles and output stalls
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int p = 0; p < N; p++) begin
                for (int k = 0; k < 3; k++) add_packet(p, 1 + $urandom_range(4));
            end
            run_traffic(25, 30, 0, 0, 3000);
        end

        // Source 1 stalls mid-packet while port 2 waits
        do_reset();
        drive(1, 8'h55, 1'b1, 1'b0);
        drive(2, 8'h66, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("stall: owner", {30'd0, grant_idx}, 32'd1);
        @(negedge clk);
        drive(1, 8'h00, 1'b0, 1'b0);
        #1;
        check("stall: first byte", {24'd0, m_tdata}, 32'h55);
`ifdef UART_ARB_TIMEOUT_EN
        hit_at = -1;
        for (int i = 1; i <= 40 && hit_at < 0; i++) begin
            @(negedge clk); #1;
            if (timeout_pulse) hit_at = i;
        end
        check("timeout: stall cycles", hit_at, TO);
        @(negedge clk); #1;
        check("timeout: pulse width", {31'd0, timeout_pulse}, 32'd0);
        check("timeout: released", {31'd0, grant_valid}, 32'd0);
        @(negedge clk); #1;
        check("timeout: next grant valid", {31'd0, grant_valid}, 32'd1);
        check("timeout: next grant idx", {30'd0, grant_idx}, 32'd2);
`else
        hit_at = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (timeout_pulse) hit_at++;
            if (i % 100 == 99) begin
                check("hold: grant_valid", {31'd0, grant_valid}, 32'd1);
                check("hold: grant_idx", {30'd0, grant_idx}, 32'd1);
            end
        end
        check("hold: no timeout pulse", hit_at, 32'd0);
        @(negedge clk);
        drive(1, 8'h56, 1'b1, 1'b1);
        #1;
        check("hold: owner ready", {28'd0, s_tready}, 32'h2);
        @(negedge clk);
        drive(1, 8'h00, 1'b0, 1'b0);
        #1;
        check("hold: last byte", {24'd0, m_tdata}, 32'h56);
        @(negedge clk); #1;
        check("hold: next grant idx", {30'd0, grant_idx}, 32'd2);
`endif
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
